// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
//   boot_state_e   : sequencer states
//   BYTES_PER_WORD : UART bytes per 32-bit word
//   timeout_width  : bit width of the inter-byte timeout counter
package uart_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StDone,
        StRun,
        StErr
    } boot_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    // At least one bit, so a degenerate TIMEOUT_CYC of 1 still yields a legal vector.
    function automatic int unsigned timeout_width(input int unsigned cyc);
        return (cyc < 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/uart_boot_loader_byte_packer.sv
// Little-endian 4-byte word assembler, shared by the length and data phases.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : assembler may take bytes (drives in_ready)
//   in_byte     : incoming byte
//   in_valid    : in_byte valid; accepted when in_valid & in_ready
//   in_ready    : byte acceptance
//   word        : assembled word, valid together with word_valid
//   word_valid  : one-cycle flag, high when the 4th byte is being accepted
module byte_packer
    import uart_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int unsigned PW = $clog2(BYTES_PER_WORD);
    localparam logic [PW-1:0] LAST_POS = PW'(BYTES_PER_WORD - 1);

    logic [PW-1:0] pos_q;
    logic [23:0]   low_q;
    logic          accept;

    assign in_ready   = en;
    assign accept     = in_valid & en;
    // The final byte is combined on the fly so the word is usable in the same cycle.
    assign word       = {in_byte, low_q};
    assign word_valid = accept && (pos_q == LAST_POS);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
            low_q <= '0;
        end else if (accept) begin
            pos_q <= pos_q + PW'(1);  // wraps 3 -> 0
            case (pos_q)
                2'd0:    low_q[7:0]   <= in_byte;
                2'd1:    low_q[15:8]  <= in_byte;
                2'd2:    low_q[23:16] <= in_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot-time sequencer: receives a 32-bit word count and program words over UART,
// writes them to instruction memory and holds the core in reset until done.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   boot_en_i             : 1 = load over UART, 0 = boot existing memory (sampled in idle)
//   rx_byte_i/valid/ready : UART byte stream, accepted on valid & ready
//   mem_*                 : instruction-memory write port (req held until gnt)
//   core_hold_o           : core held in reset
//   boot_done_o/err_o     : sticky completion / abort flags
//   words_o               : words written so far
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned MAX_WORDS   = 4096,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          boot_en_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_gnt_i,
    output logic          core_hold_o,
    output logic          boot_done_o,
    output logic          boot_err_o,
    output logic [31:0]   words_o
);

    localparam int unsigned TW = timeout_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    boot_state_e   state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   words_q, words_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_en;
    logic          rx_accept;
    logic [31:0]   pk_word;
    logic          pk_word_valid;
    logic [31:0]   addr_full;

    assign rx_en     = (state_q == StLen) || (state_q == StData);
    assign rx_accept = rx_valid_i & rx_en;
    // Byte address wraps modulo 2^AW via truncation.
    assign addr_full = BASE_ADDR + {words_q[29:0], 2'b00};
    assign words_o   = words_q;

    byte_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .en         (rx_en),
        .in_byte    (rx_byte_i),
        .in_valid   (rx_valid_i),
        .in_ready   (rx_ready_o),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            len_q   <= '0;
            words_q <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        wdata_d     = wdata_q;
        tmo_d       = tmo_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        core_hold_o = 1'b1;
        boot_done_o = 1'b0;
        boot_err_o  = 1'b0;

        case (state_q)
            StIdle: begin
                tmo_d   = '0;
                state_d = boot_en_i ? StLen : StRun;
            end
            StLen, StData: begin
                // Inter-byte watchdog: an accepted byte always wins over expiry.
                if (rx_accept) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (pk_word_valid) begin
                    if (state_q == StLen) begin
                        if ((pk_word == 32'd0) || (pk_word > 32'(MAX_WORDS))) begin
                            state_d = StErr;
                        end else begin
                            len_d   = pk_word;
                            state_d = StData;
                        end
                    end else begin
                        wdata_d = pk_word;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Request is a pure function of state and held registers, so it is
                // stable until granted; the watchdog is frozen here on purpose.
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = 4'hF;
                mem_addr_o  = addr_full[AW-1:0];
                mem_wdata_o = wdata_q;
                if (mem_gnt_i) begin
                    words_d = words_q + 32'd1;
                    tmo_d   = '0;
                    state_d = ((words_q + 32'd1) == len_q) ? StDone : StData;
                end
            end
            StDone: begin
                core_hold_o = 1'b0;
                boot_done_o = 1'b1;
            end
            StRun: begin
                core_hold_o = 1'b0;
            end
            StErr: begin
                boot_err_o = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

    localparam int unsigned AW   = 16;
    localparam logic [31:0] BASE = 32'h100;
    localparam int unsigned MAXW = 16;
    localparam int unsigned TMO  = 50;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          boot_en_i;
    logic [7:0]    rx_byte_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          mem_gnt_i;
    logic          core_hold_o;
    logic          boot_done_o;
    logic          boot_err_o;
    logic [31:0]   words_o;

    always #5 clk_i = ~clk_i;

    uart_boot_loader #(
        .AW          (AW),
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .boot_en_i   (boot_en_i),
        .rx_byte_i   (rx_byte_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .core_hold_o (core_hold_o),
        .boot_done_o (boot_done_o),
        .boot_err_o  (boot_err_o),
        .words_o     (words_o)
    );

    int checks = 0;
    int errors = 0;

    int gnt_delay = 0;
    int req_cycles = 0;
    int req_seen = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [31:0]   pend_data;
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    logic [31:0]   prog[$];

    // Memory side: grants after gnt_delay request cycles, logs writes, checks hold stability.
    initial begin
        mem_gnt_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) begin
                req_seen++;
                if (pend) begin
                    checks++;
                    if (mem_addr_o !== pend_addr || mem_wdata_o !== pend_data) begin
                        errors++;
                        $display("FAIL hold_stable got addr %h data %h want addr %h data %h",
                                 mem_addr_o, mem_wdata_o, pend_addr, pend_data);
                    end
                end
                checks++;
                if (rx_ready_o !== 1'b0 || mem_we_o !== 1'b1 || mem_be_o !== 4'hF) begin
                    errors++;
                    $display("FAIL write_ctrl got ready %b we %b be %h want 0 1 f",
                             rx_ready_o, mem_we_o, mem_be_o);
                end
                mem_gnt_i = (req_cycles >= gnt_delay);
                if (mem_gnt_i) begin
                    obs_addr.push_back(mem_addr_o);
                    obs_data.push_back(mem_wdata_o);
                    req_cycles = 0;
                    pend = 1'b0;
                end else begin
                    req_cycles++;
                    pend = 1'b1;
                    pend_addr = mem_addr_o;
                    pend_data = mem_wdata_o;
                end
            end else begin
                mem_gnt_i = 1'b0;
                req_cycles = 0;
                pend = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // All tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input int bound,
                             output bit ok);
        ok = 1'b0;
        repeat (gap) @(negedge clk_i);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        for (int n = 0; n < bound && !ok; n++) begin
            if (rx_ready_o === 1'b1) ok = 1'b1;
            @(negedge clk_i);
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_program(input logic [31:0] len_field, input int nwords,
                                input int gap_max, output int acc);
        bit ok;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(len_field[8*i +: 8], $urandom_range(gap_max, 0), 200, ok);
            acc += int'(ok);
        end
        for (int w = 0; w < nwords; w++) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] wd;
                wd = prog[w];
                send_byte(wd[8*i +: 8], $urandom_range(gap_max, 0), 200, ok);
                acc += int'(ok);
            end
        end
    endtask

    task automatic start(input bit en);
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        boot_en_i  = en;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        req_seen = 0;
    endtask

    task automatic wait_end();
        for (int n = 0; n < 200 && boot_done_o !== 1'b1 && boot_err_o !== 1'b1; n++)
            @(negedge clk_i);
    endtask

    task automatic test_reset();
        bit ok;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        boot_en_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({core_hold_o, rx_ready_o, mem_req_o, mem_we_o, boot_done_o, boot_err_o} !== 6'b100000
            || mem_addr_o !== '0 || mem_wdata_o !== 32'd0 || mem_be_o !== 4'h0
            || words_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_values got hold %b rdy %b req %b we %b done %b err %b words %0d",
                     core_hold_o, rx_ready_o, mem_req_o, mem_we_o, boot_done_o, boot_err_o,
                     words_o);
        end
        rst_i = 1'b0;
        req_seen = 0;
        checks++;
        if (core_hold_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold got %b want 1", core_hold_o);
        end
        @(negedge clk_i);
        checks++;
        if (core_hold_o !== 1'b0 || boot_done_o !== 1'b0 || boot_err_o !== 1'b0
            || mem_req_o !== 1'b0 || rx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL run_state got hold %b done %b err %b req %b rdy %b want 0 0 0 0 0",
                     core_hold_o, boot_done_o, boot_err_o, mem_req_o, rx_ready_o);
        end
        send_byte(8'h55, 0, 8, ok);
        checks++;
        if (ok !== 1'b0 || req_seen != 0) begin
            errors++;
            $display("FAIL run_ignores_rx got accepted %b reqs %0d want 0 0", ok, req_seen);
        end
    endtask

    task automatic test_fixed_load(input int delay, input string tag);
        int acc;
        gnt_delay = delay;
        start(1'b1);
        prog.delete();
        prog.push_back(32'hDEADBEEF);
        prog.push_back(32'h12345678);
        send_program(32'd2, 2, 0, acc);
        wait_end();
        checks++;
        if (acc != 12 || obs_addr.size() != 2) begin
            errors++;
            $display("FAIL %s_count got bytes %0d writes %0d want 12 2", tag, acc,
                     obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== 16'h0100 || obs_data[0] !== 32'hDEADBEEF
                || obs_addr[1] !== 16'h0104 || obs_data[1] !== 32'h12345678) begin
                errors++;
                $display("FAIL %s_writes got %h:%h %h:%h want 0100:deadbeef 0104:12345678",
                         tag, obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
            end
        end
        checks++;
        if (words_o !== 32'd2 || boot_done_o !== 1'b1 || core_hold_o !== 1'b0
            || boot_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_final got words %0d done %b hold %b err %b want 2 1 0 0",
                     tag, words_o, boot_done_o, core_hold_o, boot_err_o);
        end
    endtask

    task automatic test_bad_length();
        logic [31:0] lens[3];
        int acc;
        lens[0] = 32'd0;
        lens[1] = MAXW + 1;
        lens[2] = $urandom | 32'h0001_0000;
        gnt_delay = 0;
        for (int k = 0; k < 3; k++) begin
            start(1'b1);
            prog.delete();
            send_program(lens[k], 0, 2, acc);
            checks++;
            if (acc != 4 || boot_err_o !== 1'b1 || core_hold_o !== 1'b1 || rx_ready_o !== 1'b0
                || boot_done_o !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0d got bytes %0d err %b hold %b rdy %b done %b", k, acc,
                         boot_err_o, core_hold_o, rx_ready_o, boot_done_o);
            end
            repeat (5) @(negedge clk_i);
            checks++;
            if (req_seen != 0 || boot_err_o !== 1'b1) begin
                errors++;
                $display("FAIL bad_len_sticky_%0d got reqs %0d err %b want 0 1", k, req_seen,
                         boot_err_o);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        gnt_delay = 0;
        start(1'b1);
        send_byte(8'h01, 0, 200, ok);
        send_byte(8'h00, 3, 200, ok);
        send_byte(8'h00, 10, 200, ok);
        send_byte(8'h00, 0, 200, ok);
        send_byte(8'hAA, 20, 200, ok);
        send_byte(8'hBB, 40, 200, ok);
        n = 0;
        while (boot_err_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want %0d", n, TMO);
        end
        send_byte(8'hCC, 0, 10, ok);
        checks++;
        if (ok !== 1'b0 || core_hold_o !== 1'b1 || req_seen != 0 || words_o !== 32'd0) begin
            errors++;
            $display("FAIL timeout_sticky got accepted %b hold %b reqs %0d words %0d", ok,
                     core_hold_o, req_seen, words_o);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int acc;
        gnt_delay = 0;
        start(1'b1);
        prog.delete();
        prog.push_back($urandom);
        send_program(32'd2, 1, 1, acc);
        send_byte(8'h11, 0, 200, ok);
        send_byte(8'h22, 0, 200, ok);
        checks++;
        if (obs_addr.size() != 1 || words_o !== 32'd1) begin
            errors++;
            $display("FAIL midrst_pre got writes %0d words %0d want 1 1", obs_addr.size(),
                     words_o);
        end
        rx_byte_i  = 8'h33;
        rx_valid_i = 1'b1;
        rst_i      = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        checks++;
        if ({core_hold_o, rx_ready_o, mem_req_o, mem_we_o, boot_done_o, boot_err_o} !== 6'b100000
            || mem_addr_o !== '0 || mem_wdata_o !== 32'd0 || mem_be_o !== 4'h0
            || words_o !== 32'd0) begin
            errors++;
            $display("FAIL midrst_values got hold %b rdy %b req %b done %b err %b words %0d",
                     core_hold_o, rx_ready_o, mem_req_o, boot_done_o, boot_err_o, words_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        prog.delete();
        prog.push_back($urandom);
        prog.push_back($urandom);
        send_program(32'd2, 2, 2, acc);
        wait_end();
        checks++;
        if (obs_addr.size() != 2 || boot_done_o !== 1'b1 || words_o !== 32'd2) begin
            errors++;
            $display("FAIL midrst_reload got writes %0d done %b words %0d want 2 1 2",
                     obs_addr.size(), boot_done_o, words_o);
        end else begin
            checks++;
            if (obs_addr[0] !== BASE[AW-1:0] || obs_data[0] !== prog[0]
                || obs_addr[1] !== AW'(BASE + 32'd4) || obs_data[1] !== prog[1]) begin
                errors++;
                $display("FAIL midrst_data got %h:%h %h:%h want %h:%h %h:%h", obs_addr[0],
                         obs_data[0], obs_addr[1], obs_data[1], BASE[AW-1:0], prog[0],
                         AW'(BASE + 32'd4), prog[1]);
            end
        end
    endtask

    task automatic test_random_loads();
        int len;
        int acc;
        int bad;
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(MAXW, 1);
            // Occasional stalls longer than the byte timeout: WRITE must not time out.
            gnt_delay = ($urandom_range(3, 0) == 0) ? $urandom_range(70, 55)
                                                     : $urandom_range(3, 0);
            start(1'b1);
            prog.delete();
            for (int w = 0; w < len; w++) prog.push_back($urandom);
            send_program(32'(len), len, 5, acc);
            wait_end();
            checks++;
            if (acc != 4 + 4 * len || obs_addr.size() != len || words_o !== 32'(len)
                || boot_done_o !== 1'b1 || boot_err_o !== 1'b0 || core_hold_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d_final got bytes %0d writes %0d words %0d done %b err %b want len %0d",
                         it, acc, obs_addr.size(), words_o, boot_done_o, boot_err_o, len);
            end else begin
                bad = 0;
                for (int w = 0; w < len; w++) begin
                    if (obs_addr[w] !== AW'(BASE + 32'(4 * w)) || obs_data[w] !== prog[w])
                        bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand_%0d_writes got %0d wrong entries want 0", it, bad);
                end
            end
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        boot_en_i  = 1'b0;
        rx_byte_i  = 8'h00;
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_fixed_load(0, "basic");
        test_fixed_load(5, "stall");
        test_bad_length();
        test_timeout();
        test_reset_mid_load();
        test_random_loads();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Boot-time sequencer between the UART receiver byte stream and the instruction-memory write port of the SoC.
- When boot is enabled, it receives a 32-bit word count followed by program words over UART, writes them to memory and holds the core in reset until loading completes.
- It releases the core on success and flags an error on a bad length or a stalled stream.

Parameters:
- AW, 16, memory byte-address width.
- BASE_ADDR, 0, byte address of the first program word; must be 4-byte aligned.
- MAX_WORDS, 4096, largest accepted word count.
- TIMEOUT_CYC, 1000000, maximum clk_i cycles allowed between accepted bytes while receiving.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- boot_en_i  in  1  level; 1 = load a program over UART, 0 = boot from existing memory.
- rx_byte_i  in  8  received UART byte.
- rx_valid_i  in  1  rx_byte_i valid.
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o.
- mem_req_o  out  1  memory write request.
- mem_we_o  out  1  write enable; always 1 while mem_req_o=1.
- mem_addr_o  out  AW  byte address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables; 4'hF while mem_req_o=1.
- mem_gnt_i  in  1  request accepted this cycle.
- core_hold_o  out  1  1 = core held in reset.
- boot_done_o  out  1  load completed.
- boot_err_o  out  1  load aborted.
- words_o  out  32  number of words written so far.

Behaviour:
- Reset values: state IDLE; rx_ready_o, mem_req_o, mem_we_o, boot_done_o and boot_err_o = 0; mem_addr_o, mem_wdata_o, mem_be_o and words_o = 0; core_hold_o = 1.
- States:
  - IDLE: if boot_en_i=1, go to LEN next cycle; else go to RUN.
  - LEN: rx_ready_o=1. Collect 4 bytes little-endian (first byte goes to [7:0]). After the 4th byte:
    - length 0 or > MAX_WORDS: go to ERR.
    - otherwise: latch len and go to DATA.
  - DATA: rx_ready_o=1. Collect 4 bytes little-endian into the write buffer. After the 4th byte, go to WRITE.
  - WRITE: rx_ready_o=0.
    - Drive mem_req_o=1, mem_addr_o=BASE_ADDR+4*words_o and mem_wdata_o=buffer; all held stable until mem_gnt_i.
    - mem_gnt_i may arrive in the same cycle as the first request cycle.
    - On grant: words_o increments. If new words_o == len, go to DONE; else go to DATA. mem_req_o drops to 0 in the following cycle.
  - DONE: boot_done_o=1, core_hold_o=0. Sticky until rst_i.
  - RUN: core_hold_o=0; boot_done_o=0, boot_err_o=0. Sticky until rst_i.
  - ERR: boot_err_o=1, core_hold_o stays 1, rx_ready_o=0. Sticky until rst_i.
- core_hold_o = 1 in IDLE, LEN, DATA, WRITE and ERR; 0 in DONE and RUN.
- Timeout:
  - The counter clears on every accepted byte and on entry to LEN/DATA, and counts only in LEN and DATA.
  - When it reaches TIMEOUT_CYC-1 with no byte accepted, go to ERR on the next edge.
  - It does not count in WRITE, so memory stalls are unbounded.
- A byte offered during WRITE, DONE, ERR or RUN is not accepted (rx_ready_o=0).
- boot_en_i is sampled only in IDLE; changes afterwards are ignored.
- rst_i mid-load aborts immediately to reset values; partially written memory is left as is.
- Byte-position counter: 2 bits, wraps 3→0. words_o never exceeds len.
- Address arithmetic is modulo 2^AW.

Decomposition:
- Package uart_boot_pkg:
  - state enum (IDLE, LEN, DATA, WRITE, DONE, RUN, ERR).
  - constant BYTES_PER_WORD=4.
  - timeout counter width function $clog2(TIMEOUT_CYC).
- Sub-module byte_packer: 4-byte little-endian assembler with valid/ready in and word_valid out. It is reused for both LEN and DATA.
- The FSM, timeout counter and memory interface stay in the top module.

Test Plan:
- rst_i=1 for 3 cycles, boot_en_i=0 → core_hold_o=1 during reset, RUN one cycle after IDLE with core_hold_o=0, no mem_req_o, boot_done_o=0.
- boot_en_i=1, BASE_ADDR=0x100, bytes 02 00 00 00 | EF BE AD DE | 78 56 34 12, mem_gnt_i always 1 → writes (0x100, 0xDEADBEEF) and (0x104, 0x12345678); words_o=2; boot_done_o=1; core_hold_o=0.
- Same stream with mem_gnt_i delayed 5 cycles per request → mem_addr_o and mem_wdata_o stable throughout, rx_ready_o=0 during WRITE, no timeout, same final result.
- Length bytes 00 00 00 00, and separately MAX_WORDS+1 → ERR one cycle after the 4th byte, boot_err_o=1, core_hold_o=1, no mem_req_o.
- TIMEOUT_CYC=50, send length 1 then 2 data bytes and stop → ERR 50 cycles after the last accepted byte; later rx_valid_i not accepted.
- rst_i asserted during the 3rd data byte of word 1 → all outputs return to reset values next cycle; a new full load then succeeds starting at BASE_ADDR.
